// File: rtl/hyper_macro_bridge_buf_if.sv
// Bundle of every signal between the bridge, the uDMA core and the hyperbus
// macro, except clock and reset.
//
// Handshake semantics on every valid/ready pair: a beat transfers on a
// clock edge where valid and ready are both high. Valid never depends
// combinationally on ready, and ready never depends combinationally on valid.
interface hyper_macro_bridge_buf_if #(
   parameter int N_CH  = 2,
   parameter int DW    = 32,
   parameter int N_CFG = 2,
   parameter int EVT_W = 4
);
   // configuration, uDMA side
   logic [31:0]         cfg_data_i;
   logic [4:0]          cfg_addr_i;
   logic [N_CFG-1:0]    cfg_valid_i;
   logic                cfg_rwn_i;
   logic [N_CFG-1:0]    cfg_ready_o;
   logic [N_CFG*32-1:0] cfg_data_o;
   // configuration, macro side
   logic [31:0]         macro_cfg_data_o;
   logic [4:0]          macro_cfg_addr_o;
   logic [N_CFG-1:0]    macro_cfg_valid_o;
   logic                macro_cfg_rwn_o;
   logic [N_CFG-1:0]    macro_cfg_ready_i;
   logic [N_CFG*32-1:0] macro_cfg_data_i;
   // TX streams: uDMA push, macro pop
   logic [N_CH-1:0]     tx_valid_i;
   logic [N_CH*DW-1:0]  tx_data_i;
   logic [N_CH-1:0]     tx_ready_o;
   logic [N_CH-1:0]     tx_valid_o;
   logic [N_CH*DW-1:0]  tx_data_o;
   logic [N_CH-1:0]     tx_ready_i;
   // RX streams: macro push, uDMA pop
   logic [N_CH-1:0]     rx_valid_i;
   logic [N_CH*DW-1:0]  rx_data_i;
   logic [N_CH-1:0]     rx_ready_o;
   logic [N_CH-1:0]     rx_valid_o;
   logic [N_CH*DW-1:0]  rx_data_o;
   logic [N_CH-1:0]     rx_ready_i;
   // per-channel flush
   logic [N_CH-1:0]     tx_clr_i;
   logic [N_CH-1:0]     rx_clr_i;
   // events
   logic [EVT_W-1:0]    events_i;
   logic [EVT_W-1:0]    macro_evt_i;
   logic [EVT_W-1:0]    macro_evt_o;
   logic [EVT_W-1:0]    events_o;
   // debug view of the config FSM state
   logic [1:0]          cfg_state_o;

   // bridge side
   modport slave (
      input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
      output cfg_ready_o, cfg_data_o,
      output macro_cfg_data_o, macro_cfg_addr_o, macro_cfg_valid_o, macro_cfg_rwn_o,
      input  macro_cfg_ready_i, macro_cfg_data_i,
      input  tx_valid_i, tx_data_i, tx_ready_i, tx_clr_i,
      output tx_ready_o, tx_valid_o, tx_data_o,
      input  rx_valid_i, rx_data_i, rx_ready_i, rx_clr_i,
      output rx_ready_o, rx_valid_o, rx_data_o,
      input  events_i, macro_evt_i,
      output macro_evt_o, events_o, cfg_state_o
   );

   // environment side (uDMA core plus macro)
   modport master (
      output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
      input  cfg_ready_o, cfg_data_o,
      input  macro_cfg_data_o, macro_cfg_addr_o, macro_cfg_valid_o, macro_cfg_rwn_o,
      output macro_cfg_ready_i, macro_cfg_data_i,
      output tx_valid_i, tx_data_i, tx_ready_i, tx_clr_i,
      input  tx_ready_o, tx_valid_o, tx_data_o,
      output rx_valid_i, rx_data_i, rx_ready_i, rx_clr_i,
      input  rx_ready_o, rx_valid_o, rx_data_o,
      output events_i, macro_evt_i,
      input  macro_evt_o, events_o, cfg_state_o
   );
endinterface

// File: rtl/hyper_macro_bridge_buf.sv
// Registered bridge between the uDMA core and the hyperbus macro: per-channel
// TX/RX FIFOs, a one-outstanding config request FSM and registered events.

// Single-clock FIFO without fall-through; outputs decode from registers only.
module hmbb_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   input  logic          ready_i
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rdy_q, rdy_d;
   logic          push, pop;

   // ready is its own register so it reads low while reset is held
   assign push    = valid_i & rdy_q;
   assign pop     = valid_o & ready_i;
   assign ready_o = rdy_q;
   assign valid_o = (cnt_q != '0);
   assign data_o  = valid_o ? mem_q[rptr_q] : '0;

   // next pointers and occupancy; flush overrides push and pop
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         if (push && !pop)      cnt_d = cnt_q + CW'(1);
         else if (pop && !push) cnt_d = cnt_q - CW'(1);
      end
      rdy_d = (cnt_d < DEPTH_C);
   end

   // pointer, count and ready registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         rdy_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
      end
   end

   // storage write; a word pushed during a flush is dropped
   always_ff @(posedge clk_i) begin
      if (push && !clr_i) mem_q[wptr_q] <= data_i;
   end
endmodule

module hyper_macro_bridge_buf #(
   parameter int N_CH  = 2,
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int N_CFG = 2,
   parameter int EVT_W = 4
) (
   input  logic                      sys_clk_i,
   input  logic                      rst_i,
   hyper_macro_bridge_buf_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2
   } cfg_state_e;

   cfg_state_e          state_q, state_d;
   logic [N_CFG-1:0]    lat_v_q, lat_v_d;
   logic [31:0]         mdata_q, mdata_d;
   logic [4:0]          maddr_q, maddr_d;
   logic                mrwn_q, mrwn_d;
   logic [N_CFG-1:0]    mvalid_q, mvalid_d;
   logic [N_CFG-1:0]    crdy_q, crdy_d;
   logic [N_CFG*32-1:0] cdata_q, cdata_d;
   logic [EVT_W-1:0]    evt_to_macro_q, evt_to_udma_q;

   logic [N_CH-1:0]     tx_ready_w, tx_valid_w, rx_ready_w, rx_valid_w;
   logic [N_CH*DW-1:0]  tx_data_w, rx_data_w;

   // data FIFOs, one per direction and channel
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      hmbb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
         .clk_i   (sys_clk_i),
         .rst_i   (rst_i),
         .clr_i   (bus.tx_clr_i[c]),
         .valid_i (bus.tx_valid_i[c]),
         .data_i  (bus.tx_data_i[c*DW +: DW]),
         .ready_o (tx_ready_w[c]),
         .valid_o (tx_valid_w[c]),
         .data_o  (tx_data_w[c*DW +: DW]),
         .ready_i (bus.tx_ready_i[c])
      );
      hmbb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
         .clk_i   (sys_clk_i),
         .rst_i   (rst_i),
         .clr_i   (bus.rx_clr_i[c]),
         .valid_i (bus.rx_valid_i[c]),
         .data_i  (bus.rx_data_i[c*DW +: DW]),
         .ready_o (rx_ready_w[c]),
         .valid_o (rx_valid_w[c]),
         .data_o  (rx_data_w[c*DW +: DW]),
         .ready_i (bus.rx_ready_i[c])
      );
   end

   assign bus.tx_ready_o = tx_ready_w;
   assign bus.tx_valid_o = tx_valid_w;
   assign bus.tx_data_o  = tx_data_w;
   assign bus.rx_ready_o = rx_ready_w;
   assign bus.rx_valid_o = rx_valid_w;
   assign bus.rx_data_o  = rx_data_w;

   // config FSM next state: latch in IDLE, wait for an ack on a latched lane, pulse ready
   always_comb begin
      state_d  = state_q;
      lat_v_d  = lat_v_q;
      mdata_d  = mdata_q;
      maddr_d  = maddr_q;
      mrwn_d   = mrwn_q;
      mvalid_d = mvalid_q;
      cdata_d  = cdata_q;
      crdy_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.cfg_valid_i != '0) begin
               lat_v_d  = bus.cfg_valid_i;
               mdata_d  = bus.cfg_data_i;
               maddr_d  = bus.cfg_addr_i;
               mrwn_d   = bus.cfg_rwn_i;
               mvalid_d = bus.cfg_valid_i;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if ((bus.macro_cfg_ready_i & lat_v_q) != '0) begin
               for (int l = 0; l < N_CFG; l++) begin
                  if (lat_v_q[l]) cdata_d[l*32 +: 32] = bus.macro_cfg_data_i[l*32 +: 32];
               end
               mvalid_d = '0;
               crdy_d   = lat_v_q;
               state_d  = S_RSP;
            end
         end
         S_RSP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            mvalid_d = '0;
         end
      endcase
   end

   // config FSM state and output registers
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         lat_v_q  <= '0;
         mdata_q  <= '0;
         maddr_q  <= '0;
         mrwn_q   <= 1'b0;
         mvalid_q <= '0;
         crdy_q   <= '0;
         cdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         lat_v_q  <= lat_v_d;
         mdata_q  <= mdata_d;
         maddr_q  <= maddr_d;
         mrwn_q   <= mrwn_d;
         mvalid_q <= mvalid_d;
         crdy_q   <= crdy_d;
         cdata_q  <= cdata_d;
      end
   end

   // single register stage for events in both directions
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         evt_to_macro_q <= '0;
         evt_to_udma_q  <= '0;
      end else begin
         evt_to_macro_q <= bus.events_i;
         evt_to_udma_q  <= bus.macro_evt_i;
      end
   end

   assign bus.macro_cfg_data_o  = mdata_q;
   assign bus.macro_cfg_addr_o  = maddr_q;
   assign bus.macro_cfg_rwn_o   = mrwn_q;
   assign bus.macro_cfg_valid_o = mvalid_q;
   assign bus.cfg_ready_o       = crdy_q;
   assign bus.cfg_data_o        = cdata_q;
   assign bus.macro_evt_o       = evt_to_macro_q;
   assign bus.events_o          = evt_to_udma_q;
   assign bus.cfg_state_o       = state_q;
endmodule
